// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared constants and FSM state type for the sprite motion controller.
// Screen geometry, joystick thresholds and step sizes live here.
package sberday_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int SPRITE_W   = 128;
    localparam int SPRITE_H   = 128;
    localparam int COL_MAX    = SCREEN_W - SPRITE_W;
    localparam int ROW_MAX    = SCREEN_H - SPRITE_H;
    localparam int INIT_C     = COL_MAX / 2;
    localparam int INIT_R     = ROW_MAX / 2;
    localparam int ADC_CENTER = 2048;
    localparam int DEAD_ZONE  = 256;
    localparam int FAST_TH    = 1536;
    localparam int STEP_SLOW  = 1;
    localparam int STEP_FAST  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CALC   = 2'd2,
        APPLY  = 2'd3
    } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Frame sync, joystick/D-pad inputs and sprite position outputs.
// master drives controls and reads position; slave is the controller.
interface sprite_motion_ctrl_if;

    logic        v_sync;
    logic        freeze;
    logic [11:0] joystick_data_x;
    logic [11:0] joystick_data_y;
    logic        js_button_a;
    logic        js_button_b;
    logic        js_button_c;
    logic        js_button_d;
    logic [9:0]  stick_border_hl_c;
    logic [8:0]  stick_border_hl_r;
    logic        pos_update;
    logic        moving;

    modport master (
        output v_sync, freeze,
        output joystick_data_x, joystick_data_y,
        output js_button_a, js_button_b,
        output js_button_c, js_button_d,
        input  stick_border_hl_c, stick_border_hl_r,
        input  pos_update, moving
    );

    modport slave (
        input  v_sync, freeze,
        input  joystick_data_x, joystick_data_y,
        input  js_button_a, js_button_b,
        input  js_button_c, js_button_d,
        output stick_border_hl_c, stick_border_hl_r,
        output pos_update, moving
    );

endinterface

// File: rtl/sprite_motion_ctrl_axis_step.sv
// One axis of sprite motion: joystick speed select, D-pad override,
// and a saturating position update clamped to [0, MAX].
module axis_step
    import sberday_pkg::*;
#(
    parameter int W      = 10,
    parameter int MAX    = 512,
    parameter bit INVERT = 1'b0
) (
    input  logic [11:0]        data,
    input  logic               btn_pos_n,
    input  logic               btn_neg_n,
    input  logic               freeze,
    input  logic [W-1:0]       pos,
    input  logic signed [11:0] delta_in,
    output logic signed [11:0] delta,
    output logic [W-1:0]       next_pos
);

    localparam logic signed [11:0] MAX_S = 12'(MAX);

    logic signed [12:0] offset;
    logic [12:0]        mag;
    logic [11:0]        speed;
    logic               negative;
    logic signed [11:0] js;
    logic signed [11:0] sum;

    always_comb begin
        offset = $signed({1'b0, data} - 13'(ADC_CENTER));
        mag    = offset[12] ? 13'(-offset) : 13'(offset);
        if (mag <= 13'(DEAD_ZONE))
            speed = '0;
        else if (mag < 13'(FAST_TH))
            speed = 12'(STEP_SLOW);
        else
            speed = 12'(STEP_FAST);
        negative = offset[12] ^ INVERT;
        js = negative ? -$signed(speed) : $signed(speed);

        // Opposing buttons cancel instead of favouring one side
        delta = js;
        if (freeze || (!btn_pos_n && !btn_neg_n))
            delta = '0;
        else if (!btn_pos_n)
            delta = $signed(12'(STEP_FAST));
        else if (!btn_neg_n)
            delta = -$signed(12'(STEP_FAST));

        sum = $signed({{(12-W){1'b0}}, pos}) + delta_in;
        if (sum < 0)
            next_pos = '0;
        else if (sum > MAX_S)
            next_pos = W'(MAX);
        else
            next_pos = sum[W-1:0];
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position generator: v_sync edge detect, 4-state FSM,
// registered top-left coordinate updated only in vertical blank.
module sprite_motion_ctrl
    import sberday_pkg::*;
(
    input logic                 vga_clk,
    input logic                 arst_n,
    sprite_motion_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SAMPLE = SAMPLE;
    localparam logic [1:0] ST_CALC   = CALC;
    localparam logic [1:0] ST_APPLY  = APPLY;

    logic [1:0]         state;
    logic               vs_r, vs_d, tick;
    logic [11:0]        x_q, y_q;
    logic               btn_a_q, btn_b_q, btn_c_q, btn_d_q;
    logic               frz_q;
    logic signed [11:0] dx, dy, dx_q, dy_q;
    logic [9:0]         c_q, nc;
    logic [8:0]         r_q, nr;
    logic               pos_update_q, moving_q;

    axis_step #(.W(10), .MAX(COL_MAX), .INVERT(1'b0)) u_col (
        .data     (x_q),
        .btn_pos_n(btn_b_q),
        .btn_neg_n(btn_d_q),
        .freeze   (frz_q),
        .pos      (c_q),
        .delta_in (dx_q),
        .delta    (dx),
        .next_pos (nc)
    );

    axis_step #(.W(9), .MAX(ROW_MAX), .INVERT(1'b1)) u_row (
        .data     (y_q),
        .btn_pos_n(btn_c_q),
        .btn_neg_n(btn_a_q),
        .freeze   (frz_q),
        .pos      (r_q),
        .delta_in (dy_q),
        .delta    (dy),
        .next_pos (nr)
    );

    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= ST_IDLE;
            vs_r         <= 1'b1;
            vs_d         <= 1'b1;
            tick         <= 1'b0;
            x_q          <= 12'(ADC_CENTER);
            y_q          <= 12'(ADC_CENTER);
            btn_a_q      <= 1'b1;
            btn_b_q      <= 1'b1;
            btn_c_q      <= 1'b1;
            btn_d_q      <= 1'b1;
            frz_q        <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            c_q          <= 10'(INIT_C);
            r_q          <= 9'(INIT_R);
            pos_update_q <= 1'b0;
            moving_q     <= 1'b0;
        end else begin
            vs_r         <= bus.v_sync;
            vs_d         <= vs_r;
            tick         <= vs_d & ~vs_r;
            pos_update_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (tick)
                        state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    x_q     <= bus.joystick_data_x;
                    y_q     <= bus.joystick_data_y;
                    btn_a_q <= bus.js_button_a;
                    btn_b_q <= bus.js_button_b;
                    btn_c_q <= bus.js_button_c;
                    btn_d_q <= bus.js_button_d;
                    frz_q   <= bus.freeze;
                    state   <= ST_CALC;
                end
                ST_CALC: begin
                    dx_q  <= dx;
                    dy_q  <= dy;
                    state <= ST_APPLY;
                end
                ST_APPLY: begin
                    c_q          <= nc;
                    r_q          <= nr;
                    moving_q     <= (nc != c_q) || (nr != r_q);
                    pos_update_q <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stick_border_hl_c = c_q;
    assign bus.stick_border_hl_r = r_q;
    assign bus.pos_update        = pos_update_q;
    assign bus.moving            = moving_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scenario tasks against a per-frame arithmetic model of sprite motion.
// Covers reset, speeds, buttons, freeze, sync timing, clamping and random play.
module tb_sprite_motion_ctrl;

    logic vga_clk = 1'b0;
    logic arst_n  = 1'b0;

    sprite_motion_ctrl_if bus ();

    sprite_motion_ctrl dut (
        .vga_clk(vga_clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #20 vga_clk = ~vga_clk;

    int checks   = 0;
    int failures = 0;
    int mc = 256;
    int mr = 176;

    function automatic int axis_delta(input int data, input bit inv,
                                      input bit p_press, input bit n_press,
                                      input bit frz);
        int off, mag, step;
        if (frz) return 0;
        if (p_press && n_press) return 0;
        if (p_press) return 4;
        if (n_press) return -4;
        off  = data - 2048;
        mag  = (off < 0) ? -off : off;
        step = (mag <= 256) ? 0 : (mag < 1536) ? 1 : 4;
        if ((off < 0) != inv) step = -step;
        return step;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic set_inputs(input int x, input int y, input bit a,
                              input bit b, input bit c, input bit d,
                              input bit frz);
        bus.joystick_data_x = 12'(x);
        bus.joystick_data_y = 12'(y);
        bus.js_button_a     = a;
        bus.js_button_b     = b;
        bus.js_button_c     = c;
        bus.js_button_d     = d;
        bus.freeze          = frz;
    endtask

    task automatic do_frame(input string tag);
        int k, nc, nr, emv;
        bit seen;
        nc = clampi(mc + axis_delta(bus.joystick_data_x, 1'b0,
                    !bus.js_button_b, !bus.js_button_d, bus.freeze), 512);
        nr = clampi(mr + axis_delta(bus.joystick_data_y, 1'b1,
                    !bus.js_button_c, !bus.js_button_a, bus.freeze), 352);
        emv = (nc != mc) || (nr != mr);
        mc = nc;
        mr = nr;
        @(negedge vga_clk);
        bus.v_sync = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge vga_clk);
            k++;
            if (bus.pos_update === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s pos_update_timeout got none in %0d cycles", tag, k);
        end else if (k != 6) begin
            failures++;
            $display("FAIL %s pos_update_latency got %0d want 6", tag, k);
        end
        checks++;
        if (bus.stick_border_hl_c !== 10'(mc)) begin
            failures++;
            $display("FAIL %s col got %0d want %0d", tag,
                     bus.stick_border_hl_c, mc);
        end
        checks++;
        if (bus.stick_border_hl_r !== 9'(mr)) begin
            failures++;
            $display("FAIL %s row got %0d want %0d", tag,
                     bus.stick_border_hl_r, mr);
        end
        checks++;
        if (bus.moving !== 1'(emv)) begin
            failures++;
            $display("FAIL %s moving got %0b want %0d", tag, bus.moving, emv);
        end
        @(negedge vga_clk);
        checks++;
        if (bus.pos_update !== 1'b0) begin
            failures++;
            $display("FAIL %s pos_update_width got %0b want 0", tag,
                     bus.pos_update);
        end
        bus.v_sync = 1'b1;
        repeat (3) @(negedge vga_clk);
    endtask

    task automatic test_reset;
        int pulses;
        checks++;
        if (bus.stick_border_hl_c !== 10'd256 || bus.stick_border_hl_r !== 9'd176
            || bus.pos_update !== 1'b0 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got c=%0d r=%0d pu=%0b mv=%0b want 256 176 0 0",
                     bus.stick_border_hl_c, bus.stick_border_hl_r,
                     bus.pos_update, bus.moving);
        end
        set_inputs(4000, 2048, 1, 1, 1, 1, 0);
        do_frame("reset_pre_move");
        @(negedge vga_clk);
        bus.v_sync = 1'b0;
        repeat (4) @(negedge vga_clk);
        arst_n = 1'b0;
        #1;
        mc = 256;
        mr = 176;
        checks++;
        if (bus.stick_border_hl_c !== 10'd256 || bus.stick_border_hl_r !== 9'd176
            || bus.pos_update !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_calc got c=%0d r=%0d pu=%0b want 256 176 0",
                     bus.stick_border_hl_c, bus.stick_border_hl_r,
                     bus.pos_update);
        end
        @(negedge vga_clk);
        bus.v_sync = 1'b1;
        repeat (2) @(negedge vga_clk);
        arst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge vga_clk);
            if (bus.pos_update === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.stick_border_hl_c !== 10'd256) begin
            failures++;
            $display("FAIL reset_idle got pulses=%0d c=%0d want 0 256",
                     pulses, bus.stick_border_hl_c);
        end
    endtask

    task automatic test_dead_zone_speed;
        set_inputs(2400, 2048, 1, 1, 1, 1, 0);
        do_frame("slow_right");
        set_inputs(4000, 2048, 1, 1, 1, 1, 0);
        do_frame("fast_right_1");
        do_frame("fast_right_2");
        set_inputs(1800, 2048, 1, 1, 1, 1, 0);
        do_frame("dead_zone_x");
        set_inputs(2048, 200, 1, 1, 1, 1, 0);
        do_frame("fast_down");
        set_inputs(600, 2600, 1, 1, 1, 1, 0);
        do_frame("slow_left_up");
    endtask

    task automatic test_buttons;
        set_inputs(0, 2048, 1, 0, 1, 1, 0);
        do_frame("btn_b_override");
        set_inputs(4095, 4095, 0, 1, 0, 1, 0);
        do_frame("btn_a_c_cancel");
        set_inputs(4095, 2048, 1, 1, 1, 0, 0);
        do_frame("btn_d_left");
        set_inputs(2048, 0, 0, 1, 1, 1, 0);
        do_frame("btn_a_up");
        set_inputs(2048, 2048, 1, 0, 1, 0, 0);
        do_frame("btn_b_d_cancel");
    endtask

    task automatic test_freeze;
        set_inputs(4095, 0, 1, 1, 1, 1, 1);
        do_frame("freeze_joy");
        set_inputs(2048, 2048, 1, 0, 0, 1, 1);
        do_frame("freeze_btn");
        bus.freeze = 1'b0;
    endtask

    task automatic test_timing;
        int pulses, first;
        set_inputs(2048, 2048, 1, 0, 1, 1, 0);
        mc = clampi(mc + 4, 512);
        @(negedge vga_clk);
        bus.v_sync = 1'b0;
        pulses = 0;
        first = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge vga_clk);
            if (k == 2) bus.v_sync = 1'b1;
            if (k == 3) bus.v_sync = 1'b0;
            if (bus.pos_update === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        bus.v_sync = 1'b1;
        repeat (3) @(negedge vga_clk);
        checks++;
        if (pulses != 1 || first != 6) begin
            failures++;
            $display("FAIL timing_retrigger got pulses=%0d at=%0d want 1 at 6",
                     pulses, first);
        end
        checks++;
        if (bus.stick_border_hl_c !== 10'(mc)) begin
            failures++;
            $display("FAIL timing_col got %0d want %0d",
                     bus.stick_border_hl_c, mc);
        end
    endtask

    task automatic test_clamp;
        int guard;
        set_inputs(4095, 2048, 1, 1, 1, 1, 0);
        for (int i = 0; i < 200; i++) do_frame("clamp_right");
        checks++;
        if (bus.stick_border_hl_c !== 10'd512) begin
            failures++;
            $display("FAIL clamp_col_max got %0d want 512",
                     bus.stick_border_hl_c);
        end
        guard = 0;
        while (mr > 2 && guard < 200) begin
            if (mr - 2 >= 4) set_inputs(2048, 2048, 0, 1, 1, 1, 0);
            else set_inputs(2048, 2348, 1, 1, 1, 1, 0);
            do_frame("clamp_approach");
            guard++;
        end
        set_inputs(2048, 4095, 1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            do_frame("clamp_up");
            checks++;
            if (bus.stick_border_hl_r !== 9'd0) begin
                failures++;
                $display("FAIL clamp_row_min got %0d want 0",
                         bus.stick_border_hl_r);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            set_inputs(int'($urandom_range(4095)), int'($urandom_range(4095)),
                       $urandom_range(3) != 0, $urandom_range(3) != 0,
                       $urandom_range(3) != 0, $urandom_range(3) != 0,
                       $urandom_range(7) == 0);
            do_frame("random");
        end
    endtask

    initial begin
        bus.v_sync = 1'b1;
        set_inputs(2048, 2048, 1, 1, 1, 1, 0);
        repeat (3) @(negedge vga_clk);
        arst_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        test_reset();
        test_dead_zone_speed();
        test_buttons();
        test_freeze();
        test_timing();
        test_clamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
